// File: rtl/apb_rr_arbiter.sv
// Round-robin N-to-1 APB5 arbiter that replays the granted requester's transfer on a single completer port.
// Define APB_ARB_TIMEOUT_EN to enable the ACCESS-phase watchdog that errors out stalled completer transfers.
`timescale 1ns/1ps
module apb_rr_arbiter #(
  parameter int NUM_REQR       = 3,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                pclk,
  input  logic                                preset,
  // requester side
  input  logic [NUM_REQR*ADDR_WIDTH-1:0]      reqr_paddr,
  input  logic [NUM_REQR*3-1:0]               reqr_pprot,
  input  logic [NUM_REQR-1:0]                 reqr_pnse,
  input  logic [NUM_REQR-1:0]                 reqr_psel,
  input  logic [NUM_REQR-1:0]                 reqr_penable,
  input  logic [NUM_REQR-1:0]                 reqr_pwrite,
  input  logic [NUM_REQR-1:0]                 reqr_pwakeup,
  input  logic [NUM_REQR*DATA_WIDTH-1:0]      reqr_pwdata,
  input  logic [NUM_REQR*(DATA_WIDTH/8)-1:0]  reqr_pstrb,
  output logic [NUM_REQR-1:0]                 reqr_pready,
  output logic [NUM_REQR-1:0]                 reqr_pslverr,
  output logic [NUM_REQR*DATA_WIDTH-1:0]      reqr_prdata,
  // completer side
  output logic [ADDR_WIDTH-1:0]               comp_paddr,
  output logic [2:0]                          comp_pprot,
  output logic                                comp_pnse,
  output logic                                comp_psel,
  output logic                                comp_penable,
  output logic                                comp_pwrite,
  output logic [DATA_WIDTH-1:0]               comp_pwdata,
  output logic [(DATA_WIDTH/8)-1:0]           comp_pstrb,
  output logic                                comp_pwakeup,
  input  logic                                comp_pready,
  input  logic                                comp_pslverr,
  input  logic [DATA_WIDTH-1:0]               comp_prdata
);

  localparam int GW = (NUM_REQR > 1) ? $clog2(NUM_REQR) : 1;
  localparam int CW = GW + 1;
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] g, rr, pick, g_inc;
  logic          any_req;
  logic          timeout;
  logic          done;

  // Requester penable is deliberately ignored: the arbiter sequences the completer itself.
  logic unused_penable;
  assign unused_penable = &{1'b0, reqr_penable};

  assign any_req = |reqr_psel;
  assign done    = comp_pready | timeout;

  // Gated by reset so every output is quiet while the fabric is held in reset.
  assign comp_pwakeup = (|reqr_pwakeup) & ~preset;

  // Round-robin search: first requesting index starting at rr, wrapping modulo NUM_REQR.
  always_comb begin
    logic [CW-1:0] sum;
    logic          found;
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    pick  = rr;
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < NUM_REQR; k++) begin
      sum = {1'b0, rr} + CW'(k);
      if (sum >= CW'(NUM_REQR)) sum = sum - CW'(NUM_REQR);
      if (!found && reqr_psel[sum[GW-1:0]]) begin
        pick  = sum[GW-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    if ({1'b0, g} == CW'(NUM_REQR - 1)) g_inc = '0;
    else                                g_inc = g + GW'(1);
  end

  // State register.
  always_ff @(posedge pclk or posedge preset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (preset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant index and round-robin pointer.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      g  <= '0;
      rr <= '0;
    end else begin
      if (state == IDLE && any_req) g <= pick;
      if (state == ACCESS && done)  rr <= g_inc;
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset)                              wait_cnt <= '0;
    else if (state == SETUP)                 wait_cnt <= '0;
    else if (state == ACCESS && !comp_pready) wait_cnt <= wait_cnt + TW'(1);
  end

  // Fires on the ACCESS cycle whose stall would bring the count to TIMEOUT_CYCLES.
  assign timeout = (state == ACCESS) && !comp_pready &&
                   (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // Output logic: completer bus mux and response routing to the granted requester.
  always_comb begin
    comp_psel    = 1'b0;
    comp_penable = 1'b0;
    comp_paddr   = '0;
    comp_pprot   = '0;
    comp_pnse    = 1'b0;
    comp_pwrite  = 1'b0;
    comp_pwdata  = '0;
    comp_pstrb   = '0;
    reqr_pready  = '0;
    reqr_pslverr = '0;
    reqr_prdata  = '0;

    if (state != IDLE) begin
      comp_psel    = 1'b1;
      comp_penable = (state == ACCESS);
      comp_paddr   = reqr_paddr[int'(g)*ADDR_WIDTH +: ADDR_WIDTH];
      comp_pprot   = reqr_pprot[int'(g)*3 +: 3];
      comp_pnse    = reqr_pnse[g];
      comp_pwrite  = reqr_pwrite[g];
      comp_pwdata  = reqr_pwdata[int'(g)*DATA_WIDTH +: DATA_WIDTH];
      comp_pstrb   = reqr_pstrb[int'(g)*SW +: SW];
    end

    // A requester that dropped psel mid-transfer gets no response; a real pready beats the watchdog.
    if (state == ACCESS && done && reqr_psel[g]) begin
      reqr_pready[g]  = 1'b1;
      reqr_pslverr[g] = comp_pready ? comp_pslverr : 1'b1;
      reqr_prdata[int'(g)*DATA_WIDTH +: DATA_WIDTH] = comp_pready ? comp_prdata : '0;
    end
  end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Scoreboard bench for apb_rr_arbiter: stimulus queues expected completer requests and requester
// responses; a completer model and a response monitor pop and compare independently.
`timescale 1ns/1ps
module tb_apb_rr_arbiter;

  localparam int N  = 3;
  localparam int AW = 64;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic            pclk = 1'b0;
  logic            preset = 1'b1;
  logic [N*AW-1:0] reqr_paddr;
  logic [N*3-1:0]  reqr_pprot;
  logic [N-1:0]    reqr_pnse, reqr_psel, reqr_penable, reqr_pwrite, reqr_pwakeup;
  logic [N*DW-1:0] reqr_pwdata;
  logic [N*SW-1:0] reqr_pstrb;
  logic [N-1:0]    reqr_pready, reqr_pslverr;
  logic [N*DW-1:0] reqr_prdata;
  logic [AW-1:0]   comp_paddr;
  logic [2:0]      comp_pprot;
  logic            comp_pnse, comp_psel, comp_penable, comp_pwrite, comp_pwakeup;
  logic [DW-1:0]   comp_pwdata;
  logic [SW-1:0]   comp_pstrb;
  logic            comp_pready, comp_pslverr;
  logic [DW-1:0]   comp_prdata;

  apb_rr_arbiter #(
    .NUM_REQR(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk(pclk), .preset(preset),
    .reqr_paddr(reqr_paddr), .reqr_pprot(reqr_pprot), .reqr_pnse(reqr_pnse),
    .reqr_psel(reqr_psel), .reqr_penable(reqr_penable), .reqr_pwrite(reqr_pwrite),
    .reqr_pwakeup(reqr_pwakeup), .reqr_pwdata(reqr_pwdata), .reqr_pstrb(reqr_pstrb),
    .reqr_pready(reqr_pready), .reqr_pslverr(reqr_pslverr), .reqr_prdata(reqr_prdata),
    .comp_paddr(comp_paddr), .comp_pprot(comp_pprot), .comp_pnse(comp_pnse),
    .comp_psel(comp_psel), .comp_penable(comp_penable), .comp_pwrite(comp_pwrite),
    .comp_pwdata(comp_pwdata), .comp_pstrb(comp_pstrb), .comp_pwakeup(comp_pwakeup),
    .comp_pready(comp_pready), .comp_pslverr(comp_pslverr), .comp_prdata(comp_prdata)
  );

  initial forever #5 pclk = ~pclk;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    logic          err;
    int            cyc;
  } resp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
    logic          nse;
    logic          write;
    int            cyc;
  } req_t;

  resp_t exp_q[$];
  req_t  comp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    cfg_waits = 0;
  logic [DW-1:0] cfg_rdata = '0;
  logic          cfg_err   = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge pclk);
    cyc++;
  end

  // Completer model: checks each SETUP against the queued request, answers after cfg_waits stalls.
  initial begin
    int acc;
    acc          = 0;
    comp_pready  = 1'b0;
    comp_pslverr = 1'b0;
    comp_prdata  = '0;
    forever begin
      @(posedge pclk);
      #2;
      comp_prdata  = cfg_rdata;
      comp_pslverr = cfg_err;
      if (comp_psel && !comp_penable) begin
        if (comp_q.size() == 0) check("comp_unexpected_setup", 1, 0);
        else begin
          req_t e;
          e = comp_q.pop_front();
          check("setup_cycle", cyc, e.cyc);
          check("comp_paddr", comp_paddr, e.addr);
          check("comp_pwdata", comp_pwdata, e.wdata);
          check("comp_pstrb", comp_pstrb, e.strb);
          check("comp_ctrl", {comp_pprot, comp_pnse, comp_pwrite}, {e.prot, e.nse, e.write});
        end
      end
      if (comp_psel && comp_penable) begin
        comp_pready = (acc >= cfg_waits);
        acc++;
      end else begin
        comp_pready = 1'b0;
        acc = 0;
      end
    end
  end

  // Response monitor: pops the scoreboard whenever any requester sees pready.
  initial forever begin
    @(negedge pclk);
    if (reqr_pready !== '0) begin
      if (exp_q.size() == 0) check("resp_unexpected", reqr_pready, 0);
      else begin
        resp_t         e;
        logic [N-1:0]  oh;
        logic [N*DW-1:0] ed;
        e  = exp_q.pop_front();
        oh = '0;
        oh[e.idx] = 1'b1;
        ed = '0;
        ed[e.idx*DW +: DW] = e.data;
        check("resp_cycle", cyc, e.cyc);
        check("resp_pready", reqr_pready, oh);
        check("resp_prdata", reqr_prdata, ed);
        check("resp_pslverr", reqr_pslverr, e.err ? oh : '0);
      end
    end else begin
      check("idle_resp_zero", {reqr_pslverr, reqr_prdata}, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // Advance one cycle; requesters drop psel the cycle after they saw pready.
  task automatic tick();
    logic [N-1:0] rdy;
    @(negedge pclk);
    rdy = reqr_pready;
    @(posedge pclk);
    #1;
    reqr_psel = reqr_psel & ~rdy;
  endtask

  task automatic issue(input int i, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [SW-1:0] strb, input logic write, input logic [2:0] prot,
                       input logic nse, input int setup_off);
    req_t r;
    reqr_paddr[i*AW +: AW]  = addr;
    reqr_pwdata[i*DW +: DW] = wdata;
    reqr_pstrb[i*SW +: SW]  = strb;
    reqr_pprot[i*3 +: 3]    = prot;
    reqr_pnse[i]            = nse;
    reqr_pwrite[i]          = write;
    reqr_psel[i]            = 1'b1;
    r.addr = addr; r.wdata = wdata; r.strb = strb; r.prot = prot;
    r.nse = nse; r.write = write; r.cyc = cyc + setup_off;
    comp_q.push_back(r);
  endtask

  task automatic exp_resp(input int i, input logic [DW-1:0] data, input logic err, input int off);
    resp_t r;
    r.idx = i; r.data = data; r.err = err; r.cyc = cyc + off;
    exp_q.push_back(r);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || comp_psel) && n < budget) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    reqr_paddr = '0; reqr_pprot = '0; reqr_pnse = '0; reqr_psel = '0;
    reqr_penable = '0; reqr_pwrite = '0; reqr_pwakeup = '0;
    reqr_pwdata = '0; reqr_pstrb = '0;

    // Reset held with random requester activity: every output must stay 0.
    repeat (4) begin
      @(posedge pclk);
      #1;
      reqr_paddr   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      reqr_pwdata  = {$urandom, $urandom, $urandom};
      reqr_pstrb   = N*SW'($urandom);
      reqr_pprot   = N*3'($urandom);
      reqr_pnse    = N'($urandom);
      reqr_pwrite  = N'($urandom);
      reqr_psel    = N'($urandom) | N'(1);
      reqr_pwakeup = '1;
      #3;
      check("rst_comp_ctrl", {comp_psel, comp_penable, comp_pwrite, comp_pnse,
                              comp_pwakeup, comp_pprot, comp_pstrb}, 0);
      check("rst_comp_addr", comp_paddr, 0);
      check("rst_comp_wdata", comp_pwdata, 0);
      check("rst_reqr", {reqr_pready, reqr_pslverr, reqr_prdata}, 0);
    end
    reqr_paddr = '0; reqr_pprot = '0; reqr_pnse = '0; reqr_psel = '0;
    reqr_pwrite = '0; reqr_pwakeup = '0; reqr_pwdata = '0; reqr_pstrb = '0;
    @(posedge pclk);
    #1;
    preset = 1'b0;
    #3;
    check("post_rst_outputs", {comp_psel, comp_penable, comp_pwakeup, reqr_pready}, 0);
    repeat (3) begin
      tick();
      check("idle_no_psel", comp_psel, 0);
    end

    // pwakeup is a plain OR of the requesters, independent of state.
    reqr_pwakeup[1] = 1'b1;
    #1;
    check("pwakeup_or", comp_pwakeup, 1);
    reqr_pwakeup = '0;
    #1;
    check("pwakeup_clear", comp_pwakeup, 0);
    tick();

    // Contention, rr=0: grants 0,1,2; SETUP at T+1,T+4,T+7, responses at T+2,T+5,T+8.
    cfg_rdata = 32'hC0C0_0001;
    cfg_err   = 1'b0;
    cfg_waits = 0;
    issue(0, 64'h0000_0000_0000_0100, 32'h1111_1111, 4'hF, 1'b1, 3'b001, 1'b0, 1);
    issue(1, 64'h0000_0000_0000_0200, 32'h2222_2222, 4'h3, 1'b0, 3'b010, 1'b1, 4);
    issue(2, 64'h0000_0000_0000_0300, 32'h3333_3333, 4'hC, 1'b1, 3'b100, 1'b0, 7);
    exp_resp(0, 32'hC0C0_0001, 1'b0, 2);
    exp_resp(1, 32'hC0C0_0001, 1'b0, 5);
    exp_resp(2, 32'hC0C0_0001, 1'b0, 8);
    drain("drain_contention3", 40);

    // rr wrapped back to 0: requesters 2 and 0 together -> 0 first, then 2.
    tick();
    cfg_rdata = 32'h5A5A_0002;
    issue(2, 64'hFFFF_0000_0000_0008, 32'hAAAA_5555, 4'h1, 1'b0, 3'b111, 1'b1, 4);
    issue(0, 64'h0000_0000_FFFF_0004, 32'h0F0F_F0F0, 4'h8, 1'b1, 3'b000, 1'b0, 1);
    // Grant order is 0 then 2, so reorder the completer-side expectations to match.
    begin
      req_t a, b;
      a = comp_q.pop_back();
      b = comp_q.pop_back();
      comp_q.push_back(a);
      comp_q.push_back(b);
    end
    exp_resp(0, 32'h5A5A_0002, 1'b0, 2);
    exp_resp(2, 32'h5A5A_0002, 1'b0, 5);
    drain("drain_contention2", 40);

    // Single zero-wait write from requester 1.
    tick();
    cfg_rdata = 32'h0BAD_F00D;
    issue(1, 64'h1000_0000_0000_0040, 32'hDEAD_BEEF, 4'hF, 1'b1, 3'b000, 1'b0, 1);
    exp_resp(1, 32'h0BAD_F00D, 1'b0, 2);
    tick();
    check("write_setup_phase", {comp_psel, comp_penable}, 2'b10);
    tick();
    check("write_access_phase", {comp_psel, comp_penable}, 2'b11);
    drain("drain_write", 20);
    check("write_idle_after", {comp_psel, comp_penable}, 2'b00);

    // Read with 3 completer wait states and an error: response at T+5.
    tick();
    cfg_waits = 3;
    cfg_rdata = 32'h1234_5678;
    cfg_err   = 1'b1;
    issue(0, 64'h0000_0000_0000_0ABC, 32'h0, 4'h0, 1'b0, 3'b010, 1'b0, 1);
    exp_resp(0, 32'h1234_5678, 1'b1, 5);
    drain("drain_read_wait", 30);
    cfg_err = 1'b0;

`ifdef APB_ARB_TIMEOUT_EN
    // Stalled completer: watchdog answers on the 4th ACCESS cycle with an error and zero data.
    tick();
    cfg_waits = 100000;
    cfg_rdata = 32'hBAD0_BAD0;
    issue(2, 64'h0000_0000_0000_0DEF, 32'h0, 4'h0, 1'b0, 3'b000, 1'b0, 1);
    exp_resp(2, 32'h0, 1'b1, 5);
    drain("drain_timeout", 30);
    check("timeout_psel_drop", comp_psel, 0);
`endif

    // Reset during ACCESS of requester 2 (rr=1 beforehand in the default build).
    tick();
    cfg_waits = 100000;
    issue(2, 64'h0000_0000_0000_0222, 32'h2020_2020, 4'hF, 1'b1, 3'b000, 1'b0, 1);
    tick();
    tick();
    check("stall_access", {comp_psel, comp_penable}, 2'b11);
`ifndef APB_ARB_TIMEOUT_EN
    repeat (100) tick();
    check("stall_still_waiting", {comp_psel, comp_penable}, 2'b11);
`endif
    #2;
    preset = 1'b1;
    #1;
    check("rst_async_drop", {comp_psel, comp_penable}, 2'b00);
    check("rst_no_pready", reqr_pready, 0);
    reqr_psel = '0;
    cfg_waits = 0;
    @(posedge pclk);
    #1;
    preset = 1'b0;
    #3;
    check("rst_release_idle", {comp_psel, reqr_pready}, 0);
    tick();

    // After reset rr=0: requesters 0 and 2 together -> 0 first.
    cfg_rdata = 32'h7777_0003;
    issue(0, 64'h0000_0000_0000_0010, 32'h0101_0101, 4'h5, 1'b1, 3'b011, 1'b1, 1);
    issue(2, 64'h0000_0000_0000_0020, 32'h0202_0202, 4'hA, 1'b0, 3'b101, 1'b0, 4);
    exp_resp(0, 32'h7777_0003, 1'b0, 2);
    exp_resp(2, 32'h7777_0003, 1'b0, 5);
    drain("drain_post_rst", 40);

    tick();
    check("comp_q_empty", comp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
